// File: rtl/keypad_code_checker.sv
// Keypad code checker: takes one digit per button release, compares the finished entry with
// CODE and drives unlock, fail and lockout indications with their timeouts.
module keypad_code_checker #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter logic [31:0] CODE           = 32'h0000_1234,
  parameter logic [31:0] ENTRY_TIMEOUT  = 32'd60000000,
  parameter logic [31:0] UNLOCK_HOLD    = 32'd36000000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter logic [31:0] LOCKOUT_CYCLES = 32'd120000000
) (
  input  logic        hwclk,
  input  logic        reset,
  input  logic [3:0]  button,
  input  logic        bstate,
  output logic [2:0]  digit_count,
  output logic [31:0] entry_digits,
  output logic        unlocked,
  output logic        fail_pulse,
  output logic        locked_out,
  output logic [2:0]  fail_count
);

  typedef enum logic [2:0] {
    StIdle,
    StEntry,
    StCheck,
    StUnlocked,
    StFail,
    StLockout
  } state_e;

  localparam logic [31:0] CodeMask  = (NUM_DIGITS >= 8) ? 32'hffff_ffff :
                                      ((32'd1 << (4 * NUM_DIGITS)) - 32'd1);
  localparam logic [3:0]  LastCount = 4'(NUM_DIGITS - 1);
  localparam logic [2:0]  FailLimit = 3'(MAX_FAILS);

  state_e      state_q, state_d;
  logic        bstate_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] timer_limit;
  logic [31:0] entry_q, entry_d;
  logic [2:0]  count_q, count_d;
  logic [2:0]  fails_q, fails_d;
  logic        key_release;
  logic        digit_ok;
  logic        accept;
  logic        last_digit;
  logic        code_match;
  logic        timer_done;

  assign key_release = bstate_d & ~bstate;
  assign digit_ok    = (button != 4'd0) && (button <= 4'd9);
  assign accept      = key_release & digit_ok;
  // True when the digit about to be accepted completes the entry.
  assign last_digit  = ({1'b0, count_q} == LastCount);
  assign code_match  = ((entry_q ^ CODE) & CodeMask) == 32'd0;
  assign timer_done  = (timer_q >= timer_limit - 32'd1);

  always_comb begin
    timer_limit = 32'hffff_ffff;
    unique case (state_q)
      StEntry:    timer_limit = ENTRY_TIMEOUT;
      StUnlocked: timer_limit = UNLOCK_HOLD;
      StLockout:  timer_limit = LOCKOUT_CYCLES;
      default:    ;
    endcase
  end

  // State register.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = last_digit ? StCheck : StEntry;
      end
      StEntry: begin
        if (accept) begin
          if (last_digit) state_d = StCheck;
        end else if (timer_done) begin
          state_d = StIdle;
        end
      end
      StCheck:    state_d = code_match ? StUnlocked : StFail;
      StUnlocked: if (timer_done) state_d = StIdle;
      StFail:     state_d = (fails_q >= FailLimit) ? StLockout : StIdle;
      StLockout:  if (timer_done) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Datapath next-state: entry shift register, digit/fail counters and the shared timer.
  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    fails_d = fails_q;
    timer_d = (state_d == state_q) ? timer_q + 32'd1 : 32'd0;
    unique case (state_q)
      StIdle: begin
        timer_d = 32'd0;
        if (accept) begin
          entry_d = {28'd0, button};
          count_d = 3'd1;
        end
      end
      StEntry: begin
        if (accept) begin
          entry_d = {entry_q[27:0], button};
          count_d = count_q + 3'd1;
          timer_d = 32'd0;
        end else if (timer_done) begin
          entry_d = 32'd0;
          count_d = 3'd0;
        end
      end
      StCheck: begin
        entry_d = 32'd0;
        count_d = 3'd0;
        if (code_match) begin
          fails_d = 3'd0;
        end else if (fails_q != 3'd7) begin
          fails_d = fails_q + 3'd1;
        end
      end
      StLockout: begin
        if (timer_done) fails_d = 3'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      bstate_d <= 1'b0;
      timer_q  <= 32'd0;
      entry_q  <= 32'd0;
      count_q  <= 3'd0;
      fails_q  <= 3'd0;
    end else begin
      bstate_d <= bstate;
      timer_q  <= timer_d;
      entry_q  <= entry_d;
      count_q  <= count_d;
      fails_q  <= fails_d;
    end
  end

  // Output decode.
  always_comb begin
    unlocked   = 1'b0;
    fail_pulse = 1'b0;
    locked_out = 1'b0;
    unique case (state_q)
      StUnlocked: unlocked   = 1'b1;
      StFail:     fail_pulse = 1'b1;
      StLockout:  locked_out = 1'b1;
      default:    ;
    endcase
    digit_count  = count_q;
    entry_digits = entry_q;
    fail_count   = fails_q;
  end

endmodule
